// File: rtl/matmul_8x8_sequencer.sv
// Job sequencer for the 8x8 int8 matmul datapath: streams A/B into the BRAMs, runs the
// multiply, then reads C back out over a ready/valid stream while hiding addr/enable timing.
module matmul_8x8_sequencer #(
    parameter int DWIDTH  = 8,
    parameter int AWIDTH  = 7,
    parameter int WORD_W  = 4 * DWIDTH,
    parameter int A_WORDS = 8,
    parameter int B_WORDS = 8,
    parameter int C_WORDS = 8,
    parameter int WR_LEAD = 2,
    parameter int RD_LAT  = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    output logic              busy,
    output logic              job_done,
    output logic              err_timeout,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              enable_writing_to_mem,
    output logic              enable_reading_from_mem,
    output logic [AWIDTH-1:0] addr_pi,
    output logic [WORD_W-1:0] data_pi,
    output logic              we_a,
    output logic              we_b,
    output logic              we_c,
    output logic              start_mat_mul,
    input  logic              done_mat_mul,
    input  logic [WORD_W-1:0] data_from_out_mat
);

    localparam int TWIDTH = $clog2(TIMEOUT + 1);
    localparam int LWIDTH = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_A     = 3'd1,
        S_LOAD_B     = 3'd2,
        S_FLUSH      = 3'd3,
        S_COMPUTE    = 3'd4,
        S_READ_ISSUE = 3'd5,
        S_READ_WAIT  = 3'd6,
        S_READ_OUT   = 3'd7
    } state_t;

    state_t              r_state;
    logic [AWIDTH-1:0]   r_cnt;
    logic [TWIDTH-1:0]   r_tmo;
    logic [LWIDTH-1:0]   r_lat;
    logic                r_busy;
    logic                r_job_done;
    logic                r_err_timeout;
    logic                r_in_ready;
    logic [WORD_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_en_wr;
    logic                r_en_rd;
    logic [AWIDTH-1:0]   r_addr_pi;
    logic [WORD_W-1:0]   r_data_pi;
    logic                r_we_a;
    logic                r_we_b;
    logic                r_we_c;
    logic                r_start;

    // Write-data delay pipe: addr_pi is registered on the beat, data/we leave WR_LEAD cycles later.
    logic                r_pipe_vld  [WR_LEAD];
    logic                r_pipe_isb  [WR_LEAD];
    logic [WORD_W-1:0]   r_pipe_data [WR_LEAD];

    assign busy                    = r_busy;
    assign job_done                = r_job_done;
    assign err_timeout             = r_err_timeout;
    assign in_ready                = r_in_ready;
    assign out_data                = r_out_data;
    assign out_valid               = r_out_valid;
    assign enable_writing_to_mem   = r_en_wr;
    assign enable_reading_from_mem = r_en_rd;
    assign addr_pi                 = r_addr_pi;
    assign data_pi                 = r_data_pi;
    assign we_a                    = r_we_a;
    assign we_b                    = r_we_b;
    assign we_c                    = r_we_c;
    assign start_mat_mul           = r_start;

    // Job FSM with all outputs, counters and the write-delay pipe registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_tmo         <= '0;
            r_lat         <= '0;
            r_busy        <= 1'b0;
            r_job_done    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_in_ready    <= 1'b0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_en_wr       <= 1'b0;
            r_en_rd       <= 1'b0;
            r_addr_pi     <= '0;
            r_data_pi     <= '0;
            r_we_a        <= 1'b0;
            r_we_b        <= 1'b0;
            r_we_c        <= 1'b0;
            r_start       <= 1'b0;
            for (int i = 0; i < WR_LEAD; i++) begin
                r_pipe_vld[i]  <= 1'b0;
                r_pipe_isb[i]  <= 1'b0;
                r_pipe_data[i] <= '0;
            end
        end else begin
            r_job_done     <= 1'b0;
            r_pipe_vld[0]  <= 1'b0;
            r_pipe_isb[0]  <= 1'b0;
            r_pipe_data[0] <= '0;
            for (int i = 1; i < WR_LEAD; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_isb[i]  <= r_pipe_isb[i-1];
                r_pipe_data[i] <= r_pipe_data[i-1];
            end
            r_we_a    <= r_pipe_vld[WR_LEAD-1] && !r_pipe_isb[WR_LEAD-1];
            r_we_b    <= r_pipe_vld[WR_LEAD-1] && r_pipe_isb[WR_LEAD-1];
            r_data_pi <= r_pipe_data[WR_LEAD-1];

            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_state       <= S_LOAD_A;
                        r_cnt         <= '0;
                        r_err_timeout <= 1'b0;
                        r_busy        <= 1'b1;
                        r_in_ready    <= 1'b1;
                        r_en_wr       <= 1'b1;
                    end
                end
                S_LOAD_A: begin
                    if (in_valid && r_in_ready) begin
                        r_addr_pi      <= r_cnt;
                        r_pipe_vld[0]  <= 1'b1;
                        r_pipe_isb[0]  <= 1'b0;
                        r_pipe_data[0] <= in_data;
                        if (r_cnt == AWIDTH'(A_WORDS - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_LOAD_B;
                        end else begin
                            r_cnt <= r_cnt + AWIDTH'(1);
                        end
                    end
                end
                S_LOAD_B: begin
                    if (in_valid && r_in_ready) begin
                        r_addr_pi      <= r_cnt;
                        r_pipe_vld[0]  <= 1'b1;
                        r_pipe_isb[0]  <= 1'b1;
                        r_pipe_data[0] <= in_data;
                        if (r_cnt == AWIDTH'(B_WORDS - 1)) begin
                            r_cnt      <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= S_FLUSH;
                        end else begin
                            r_cnt <= r_cnt + AWIDTH'(1);
                        end
                    end
                end
                // The last we_b lands WR_LEAD cycles after its address; keep the write enable up until then.
                S_FLUSH: begin
                    if (r_cnt == AWIDTH'(WR_LEAD)) begin
                        r_cnt   <= '0;
                        r_en_wr <= 1'b0;
                        r_start <= 1'b1;
                        r_we_c  <= 1'b1;
                        r_tmo   <= '0;
                        r_state <= S_COMPUTE;
                    end else begin
                        r_cnt <= r_cnt + AWIDTH'(1);
                    end
                end
                S_COMPUTE: begin
                    if (done_mat_mul) begin
                        r_start   <= 1'b0;
                        r_we_c    <= 1'b0;
                        r_cnt     <= '0;
                        r_addr_pi <= '0;
                        r_en_rd   <= 1'b1;
                        r_state   <= S_READ_ISSUE;
                    end else if (r_tmo == TWIDTH'(TIMEOUT - 1)) begin
                        r_start       <= 1'b0;
                        r_we_c        <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TWIDTH'(1);
                    end
                end
                S_READ_ISSUE: begin
                    r_lat   <= LWIDTH'(1);
                    r_state <= S_READ_WAIT;
                end
                S_READ_WAIT: begin
                    if (r_lat == LWIDTH'(RD_LAT)) begin
                        r_out_data  <= data_from_out_mat;
                        r_out_valid <= 1'b1;
                        r_en_rd     <= 1'b0;
                        r_state     <= S_READ_OUT;
                    end else begin
                        r_lat <= r_lat + LWIDTH'(1);
                    end
                end
                S_READ_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_cnt == AWIDTH'(C_WORDS - 1)) begin
                            r_job_done <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_cnt     <= r_cnt + AWIDTH'(1);
                            r_addr_pi <= r_cnt + AWIDTH'(1);
                            r_en_rd   <= 1'b1;
                            r_state   <= S_READ_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_en_wr     <= 1'b0;
                    r_en_rd     <= 1'b0;
                    r_start     <= 1'b0;
                    r_we_c      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_8x8_sequencer.sv
// Scoreboard bench for matmul_8x8_sequencer with a behavioural datapath responder.
module tb_matmul_8x8_sequencer;

    localparam int WR_LEAD = 2;
    localparam int RD_LAT  = 4;
    localparam int TIMEOUT = 1023;
    localparam int NW      = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        done_mat_mul = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic [31:0] data_from_out_mat = 32'h0;
    logic        busy, job_done, err_timeout, in_ready, out_valid;
    logic        enable_writing_to_mem, enable_reading_from_mem;
    logic        we_a, we_b, we_c, start_mat_mul;
    logic [31:0] out_data, data_pi;
    logic [6:0]  addr_pi;

    matmul_8x8_sequencer dut (
        .clk(clk), .reset(reset), .go(go), .busy(busy), .job_done(job_done),
        .err_timeout(err_timeout), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .enable_writing_to_mem(enable_writing_to_mem), .enable_reading_from_mem(enable_reading_from_mem),
        .addr_pi(addr_pi), .data_pi(data_pi), .we_a(we_a), .we_b(we_b), .we_c(we_c),
        .start_mat_mul(start_mat_mul), .done_mat_mul(done_mat_mul), .data_from_out_mat(data_from_out_mat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q [$];
    logic [7:0]  wr_log [$];
    logic [31:0] mem_a [128];
    logic [31:0] mem_b [128];
    logic [31:0] mem_c [128];
    bit          never_done = 1'b0;
    bit          hold_ready = 1'b0;
    bit          stall_en = 1'b0;
    int          done_count = 0;
    int          tot_compute = 0;
    int          last_lat = 0;
    int          viol = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Datapath function: 4-byte row of A times (B rows 0..3 + B rows 4..7), bytewise mod 256.
    function automatic logic [31:0] mm_word(input logic [31:0] a, input logic [31:0] b [8]);
        logic [31:0] r;
        logic [7:0]  acc;
        for (int j = 0; j < 4; j++) begin
            acc = 8'd0;
            for (int k = 0; k < 4; k++)
                acc = acc + a[8*k +: 8] * (b[k][8*j +: 8] + b[k+4][8*j +: 8]);
            r[8*j +: 8] = acc;
        end
        return r;
    endfunction

    // Datapath responder: BRAM writes with WR_LEAD-delayed address, RD_LAT read latency, done after a random delay.
    initial begin
        logic [6:0]  a_hist [9];
        logic        e_hist [9];
        logic [31:0] bl [8];
        int          cmp_cnt;
        int          lat;
        cmp_cnt = 0;
        lat = 0;
        for (int i = 0; i < 9; i++) begin a_hist[i] = 7'd0; e_hist[i] = 1'b0; end
        forever begin
            @(negedge clk);
            if (reset) begin
                cmp_cnt = 0;
                done_mat_mul = 1'b0;
                data_from_out_mat = 32'h0;
                for (int i = 0; i < 9; i++) begin a_hist[i] = 7'd0; e_hist[i] = 1'b0; end
            end else begin
                for (int i = 8; i > 0; i--) begin a_hist[i] = a_hist[i-1]; e_hist[i] = e_hist[i-1]; end
                a_hist[0] = addr_pi;
                e_hist[0] = enable_reading_from_mem;
                if (we_a) begin mem_a[a_hist[WR_LEAD]] = data_pi; wr_log.push_back({1'b0, a_hist[WR_LEAD]}); end
                if (we_b) begin mem_b[a_hist[WR_LEAD]] = data_pi; wr_log.push_back({1'b1, a_hist[WR_LEAD]}); end
                if ((we_a || we_b) && !enable_writing_to_mem) begin viol++; $display("protocol: write strobe without enable at %0t", $time); end
                if (enable_writing_to_mem && enable_reading_from_mem) begin viol++; $display("protocol: enables overlap at %0t", $time); end
                if (we_c && !start_mat_mul) begin viol++; $display("protocol: we_c outside compute at %0t", $time); end
                if ((start_mat_mul || we_a || we_b) && !busy) begin viol++; $display("protocol: strobe while idle at %0t", $time); end
                if (start_mat_mul) begin
                    if (cmp_cnt == 0) begin lat = $urandom_range(3, 30); last_lat = lat; end
                    cmp_cnt++;
                    tot_compute++;
                    if (!never_done && cmp_cnt == lat) begin
                        for (int k = 0; k < 8; k++) bl[k] = mem_b[k];
                        for (int i = 0; i < NW; i++) mem_c[i] = mm_word(mem_a[i], bl);
                        done_mat_mul = 1'b1;
                    end else begin
                        done_mat_mul = 1'b0;
                    end
                end else begin
                    cmp_cnt = 0;
                    done_mat_mul = 1'b0;
                end
                data_from_out_mat = e_hist[RD_LAT] ? mem_c[a_hist[RD_LAT]] : 32'hDEAD_BEEF;
            end
        end
    end

    // Output monitor: drives out_ready with stalls, pops the scoreboard on each handshake.
    initial begin
        bit          prev_wait;
        logic [31:0] prev_data;
        int          stall_left;
        int          words;
        int          last_hs;
        prev_wait = 1'b0; prev_data = 32'h0; stall_left = 0; words = 0; last_hs = -10;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_wait = 1'b0;
                words = 0;
                out_ready = 1'b0;
            end else begin
                if (prev_wait) chk("out_hold", {out_valid, out_data}, {1'b1, prev_data});
                if (job_done) begin
                    done_count++;
                    chk("job_done_timing", {32'(words), 32'(cyc)}, {32'(NW), 32'(last_hs)});
                    words = 0;
                end
                if (out_valid) begin
                    if (hold_ready || stall_left > 0) begin
                        out_ready = 1'b0;
                        if (!hold_ready) stall_left--;
                        prev_wait = 1'b1;
                        prev_data = out_data;
                    end else begin
                        out_ready = 1'b1;
                        prev_wait = 1'b0;
                        chk("word_expected", exp_q.size() != 0, 1'b1);
                        if (exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
                        words++;
                        last_hs = cyc + 1;
                        stall_left = stall_en ? int'($urandom_range(0, 5)) : 0;
                    end
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                    prev_wait = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        go = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {busy, job_done, err_timeout, in_ready, out_data, out_valid,
                              enable_writing_to_mem, enable_reading_from_mem, addr_pi, data_pi,
                              we_a, we_b, we_c, start_mat_mul}, 128'h0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    // abort_at: 0 = run to completion, 1 = reset during LOAD_B, 2 = reset during READ_OUT.
    task automatic run_job(input bit directed, input int maxgap, input bit noise,
                           input int abort_at, input int pre_idle, input bit tmo_job);
        logic [31:0]  a [8];
        logic [31:0]  b [8];
        logic [127:0] exp_log;
        logic [127:0] act_log;
        int           t;
        int           gap;
        int           done_before;
        for (int i = 0; i < 8; i++) begin
            a[i] = directed ? 32'h0101_0101 : $urandom;
            b[i] = directed ? ((i < 4) ? (32'h1 << (8 * i)) : 32'h0) : $urandom;
        end
        repeat (pre_idle) @(negedge clk);
        never_done = tmo_job;
        if (abort_at == 0 && !tmo_job)
            for (int i = 0; i < NW; i++) exp_q.push_back(mm_word(a[i], b));
        wr_log.delete();
        tot_compute = 0;
        done_before = done_count;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("go_start", {busy, err_timeout}, 2'b10);
        for (int i = 0; i < 16; i++) begin
            if (abort_at == 1 && i == 11) begin
                do_reset();
                return;
            end
            gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data = (i < 8) ? a[i] : b[i-8];
            t = 0;
            while (!in_ready && t < 100) begin @(negedge clk); t++; end
            if (!in_ready) begin
                chk("in_ready_wait", in_ready, 1'b1);
                do_reset();
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (abort_at == 2) begin
            hold_ready = 1'b1;
            t = 0;
            while (!out_valid && t < 3000) begin @(negedge clk); t++; end
            chk("read_out_reached", out_valid, 1'b1);
            do_reset();
            hold_ready = 1'b0;
            return;
        end
        t = 0;
        while (busy && t < 4000) begin
            go = noise && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            t++;
        end
        go = 1'b0;
        chk("job_end", busy, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            exp_log[8*i +: 8] = {(i >= 8) ? 1'b1 : 1'b0, 7'(i % 8)};
            act_log[8*i +: 8] = (i < wr_log.size()) ? wr_log[i] : 8'hFF;
        end
        chk("write_count", wr_log.size(), 16);
        chk("write_order", act_log, exp_log);
        if (tmo_job) begin
            chk("timeout_err", err_timeout, 1'b1);
            chk("timeout_no_done", done_count, done_before);
            chk("timeout_cycles", tot_compute, TIMEOUT);
        end else begin
            chk("job_done_count", done_count, done_before + 1);
            chk("all_words_out", exp_q.size(), 0);
            chk("compute_cycles", tot_compute, last_lat);
            chk("no_err", err_timeout, 1'b0);
        end
        never_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", {busy, job_done, err_timeout, in_ready, out_data, out_valid,
                            enable_writing_to_mem, enable_reading_from_mem, addr_pi, data_pi,
                            we_a, we_b, we_c, start_mat_mul}, 128'h0);
        reset = 1'b0;
        run_job(1'b1, 0, 1'b0, 0, 1, 1'b0);
        stall_en = 1'b1;
        repeat (4) run_job(1'b0, 5, 1'b0, 0, int'($urandom_range(0, 3)), 1'b0);
        run_job(1'b0, 2, 1'b1, 0, 1, 1'b0);
        run_job(1'b0, 0, 1'b0, 0, 1, 1'b1);
        run_job(1'b0, 1, 1'b0, 0, 2, 1'b0);
        run_job(1'b0, 0, 1'b0, 1, 1, 1'b0);
        run_job(1'b0, 2, 1'b0, 0, 1, 1'b0);
        run_job(1'b0, 0, 1'b0, 2, 1, 1'b0);
        run_job(1'b0, 2, 1'b0, 0, 1, 1'b0);
        stall_en = 1'b0;
        run_job(1'b0, 0, 1'b0, 0, 1, 1'b0);
        run_job(1'b0, 0, 1'b0, 0, 0, 1'b0);
        chk("protocol_violations", viol, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
